// File: rtl/pkg_movimento.sv
// Shared types and widths for the square motion sequencer.
package pkg_movimento;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;
  localparam int unsigned XW        = 10;
  localparam int unsigned YW        = 9;
  localparam int unsigned TAM_W     = 7;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned SETTLE_W  = 3;
  localparam int unsigned EDGE_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_t;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_t;

  // Request captured at frame start and held for the whole frame
  typedef struct packed {
    dir_t              dir_x;
    dir_t              dir_y;
    logic [TAM_W-1:0]  tamanho;
  } frame_req_t;

  // Opposing keys cancel each other
  function automatic dir_t decode_dir(input logic key_pos, input logic key_neg);
    dir_t d;
    d = DIR_NONE;
    if (key_pos && !key_neg) d = DIR_POS;
    else if (key_neg && !key_pos) d = DIR_NEG;
    return d;
  endfunction

endpackage

// File: rtl/movimento_arbitro.sv
// Step legality check for the pointed axis and next-axis selection.
module movimento_arbitro
  import pkg_movimento::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  axis_t             axis_ptr,
  input  frame_req_t        req,
  input  logic [XW-1:0]     xpos,
  input  logic [YW-1:0]     ypos,
  input  logic [CNT_W-1:0]  cnt_x,
  input  logic [CNT_W-1:0]  cnt_y,
  input  logic              colisao_max_x,
  input  logic              colisao_min_x,
  input  logic              colisao_max_y,
  input  logic              colisao_min_y,
  output logic              allowed_c,
  output axis_t             next_axis_c,
  output logic              last_step_c
);

  logic [EDGE_W-1:0] x_far;
  logic [EDGE_W-1:0] y_far;
  logic              right_ok;
  logic              left_ok;
  logic              down_ok;
  logic              up_ok;
  logic              x_left;
  logic              y_left;

  // Far-edge sums are widened so they never wrap near the screen limit
  always_comb begin
    x_far    = EDGE_W'(xpos) + EDGE_W'(req.tamanho) + EDGE_W'(1);
    y_far    = EDGE_W'(ypos) + EDGE_W'(req.tamanho) + EDGE_W'(1);
    right_ok = !colisao_max_x && (x_far <= EDGE_W'(H_RES));
    left_ok  = !colisao_min_x && (xpos != '0);
    down_ok  = !colisao_max_y && (y_far <= EDGE_W'(V_RES));
    up_ok    = !colisao_min_y && (ypos != '0);
  end

  // Legality of the sub-step on the pointed axis
  always_comb begin
    allowed_c = 1'b0;
    if (axis_ptr == AXIS_X) begin
      case (req.dir_x)
        DIR_POS: allowed_c = right_ok;
        DIR_NEG: allowed_c = left_ok;
        default: allowed_c = 1'b0;
      endcase
    end else begin
      case (req.dir_y)
        DIR_POS: allowed_c = down_ok;
        DIR_NEG: allowed_c = up_ok;
        default: allowed_c = 1'b0;
      endcase
    end
  end

  // Remaining work after this EVAL; alternate axes while both have steps left
  always_comb begin
    if (axis_ptr == AXIS_X) begin
      x_left = allowed_c && (cnt_x > CNT_W'(1));
      y_left = (cnt_y != '0);
    end else begin
      x_left = (cnt_x != '0);
      y_left = allowed_c && (cnt_y > CNT_W'(1));
    end
    if (axis_ptr == AXIS_X) next_axis_c = y_left ? AXIS_Y : AXIS_X;
    else                    next_axis_c = x_left ? AXIS_X : AXIS_Y;
    last_step_c = !x_left && !y_left;
  end

endmodule

// File: rtl/controle_movimento.sv
// Per-frame motion sequencer: turns held keys into settled 1-pixel sub-steps.
module controle_movimento
  import pkg_movimento::*;
#(
  parameter int unsigned X_INI  = 20,
  parameter int unsigned Y_INI  = 20,
  parameter int unsigned STEP   = 4,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned H_RES  = H_RES_DEF,
  parameter int unsigned V_RES  = V_RES_DEF
) (
  input  logic              VGA_clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              key_right,
  input  logic              key_left,
  input  logic              key_up,
  input  logic              key_down,
  input  logic [TAM_W-1:0]  tamanho,
  input  logic              colisao_max_x,
  input  logic              colisao_min_x,
  input  logic              colisao_max_y,
  input  logic              colisao_min_y,
  output logic [XW-1:0]     xPos,
  output logic [YW-1:0]     yPos,
  output logic              busy,
  output logic              bloqueado,
  output logic              done,
  output logic              frame_overrun
);

  state_t               state_q, state_d;
  frame_req_t           req_q, req_d;
  axis_t                axis_q, axis_d;
  logic [XW-1:0]        xpos_q, xpos_d;
  logic [YW-1:0]        ypos_q, ypos_d;
  logic [CNT_W-1:0]     cnt_x_q, cnt_x_d;
  logic [CNT_W-1:0]     cnt_y_q, cnt_y_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 busy_q, busy_d;
  logic                 bloq_q, bloq_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  dir_t                 dir_x_c;
  dir_t                 dir_y_c;
  logic                 allowed_c;
  axis_t                next_axis_c;
  logic                 last_step_c;

  movimento_arbitro #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_arbitro (
    .axis_ptr      (axis_q),
    .req           (req_q),
    .xpos          (xpos_q),
    .ypos          (ypos_q),
    .cnt_x         (cnt_x_q),
    .cnt_y         (cnt_y_q),
    .colisao_max_x (colisao_max_x),
    .colisao_min_x (colisao_min_x),
    .colisao_max_y (colisao_max_y),
    .colisao_min_y (colisao_min_y),
    .allowed_c     (allowed_c),
    .next_axis_c   (next_axis_c),
    .last_step_c   (last_step_c)
  );

  // Key decode used only at frame start
  always_comb begin
    dir_x_c = decode_dir(key_right, key_left);
    dir_y_c = decode_dir(key_down, key_up);
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    axis_d    = axis_q;
    xpos_d    = xpos_q;
    ypos_d    = ypos_q;
    cnt_x_d   = cnt_x_q;
    cnt_y_d   = cnt_y_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    bloq_d    = 1'b0;
    done_d    = 1'b0;
    overrun_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          req_d.dir_x   = dir_x_c;
          req_d.dir_y   = dir_y_c;
          req_d.tamanho = tamanho;
          cnt_x_d = (dir_x_c != DIR_NONE) ? CNT_W'(STEP) : '0;
          cnt_y_d = (dir_y_c != DIR_NONE) ? CNT_W'(STEP) : '0;
          if ((dir_x_c == DIR_NONE) && (dir_y_c == DIR_NONE)) begin
            done_d = 1'b1;
          end else begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_W'(SETTLE);
            busy_d   = 1'b1;
            axis_d   = (dir_x_c != DIR_NONE) ? AXIS_X : AXIS_Y;
          end
        end
      end

      ST_SETTLE: begin
        overrun_d = frame_tick;
        if (settle_q <= SETTLE_W'(1)) state_d = ST_EVAL;
        else                          settle_d = settle_q - SETTLE_W'(1);
      end

      ST_EVAL: begin
        overrun_d = frame_tick;
        if (axis_q == AXIS_X) begin
          if (allowed_c) begin
            xpos_d  = (req_q.dir_x == DIR_POS) ? xpos_q + XW'(1) : xpos_q - XW'(1);
            cnt_x_d = cnt_x_q - CNT_W'(1);
          end else begin
            cnt_x_d = '0;
            bloq_d  = 1'b1;
          end
        end else begin
          if (allowed_c) begin
            ypos_d  = (req_q.dir_y == DIR_POS) ? ypos_q + YW'(1) : ypos_q - YW'(1);
            cnt_y_d = cnt_y_q - CNT_W'(1);
          end else begin
            cnt_y_d = '0;
            bloq_d  = 1'b1;
          end
        end
        axis_d = next_axis_c;
        if (last_step_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_W'(SETTLE);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge VGA_clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      axis_q    <= AXIS_X;
      xpos_q    <= XW'(X_INI);
      ypos_q    <= YW'(Y_INI);
      cnt_x_q   <= '0;
      cnt_y_q   <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      bloq_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      axis_q    <= axis_d;
      xpos_q    <= xpos_d;
      ypos_q    <= ypos_d;
      cnt_x_q   <= cnt_x_d;
      cnt_y_q   <= cnt_y_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      bloq_q    <= bloq_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign xPos          = xpos_q;
  assign yPos          = ypos_q;
  assign busy          = busy_q;
  assign bloqueado     = bloq_q;
  assign done          = done_q;
  assign frame_overrun = overrun_q;

endmodule
